// File: rtl/sseg_mux4.sv
// Four-digit common-anode seven-segment scanner with per-slot input snapshot and anode dead-time.
// Optional macro SSEG_DIM_EN adds a dim[3:0] port that PWM-gates the lit window with a 4-bit phase counter.
module sseg_mux4 #(
  parameter int REFRESH_DIV  = 50_000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] in_0,
  input  logic [4:0] in_1,
  input  logic [4:0] in_2,
  input  logic [4:0] in_3,
  input  logic [3:0] dp_in,
`ifdef SSEG_DIM_EN
  input  logic [3:0] dim,
`endif
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic [1:0] digit_idx,
  output logic       scan_tick
);

  localparam int            CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [3:0]    AN_OFF    = {4{ACTIVE_LOW}};
  localparam logic [7:0]    SSEG_OFF  = {8{ACTIVE_LOW}};

  logic [CW-1:0] cnt;
  logic          slot_end;
  logic [1:0]    idx_nxt;
  logic [4:0]    word_nxt;
  logic [5:0]    snap;      // {dp, blank, hex} of the digit being shown
  logic [5:0]    snap_nxt;
  logic [6:0]    seg_pat;
  logic          lit;
  logic [3:0]    an_int;
  logic [7:0]    sseg_int;

  assign slot_end = (cnt == CNT_LAST);
  assign idx_nxt  = digit_idx + 2'd1;

  always_comb begin
    word_nxt = in_0;
    case (idx_nxt)
      2'd0: word_nxt = in_0;
      2'd1: word_nxt = in_1;
      2'd2: word_nxt = in_2;
      2'd3: word_nxt = in_3;
      default: word_nxt = in_0;
    endcase
  end

  assign snap_nxt = {dp_in[idx_nxt], word_nxt};

  always_comb begin
    seg_pat = 7'h00;
    case (snap[3:0])
      4'h0: seg_pat = 7'h3F;
      4'h1: seg_pat = 7'h06;
      4'h2: seg_pat = 7'h5B;
      4'h3: seg_pat = 7'h4F;
      4'h4: seg_pat = 7'h66;
      4'h5: seg_pat = 7'h6D;
      4'h6: seg_pat = 7'h7D;
      4'h7: seg_pat = 7'h07;
      4'h8: seg_pat = 7'h7F;
      4'h9: seg_pat = 7'h6F;
      4'hA: seg_pat = 7'h77;
      4'hB: seg_pat = 7'h7C;
      4'hC: seg_pat = 7'h39;
      4'hD: seg_pat = 7'h5E;
      4'hE: seg_pat = 7'h79;
      4'hF: seg_pat = 7'h71;
      default: seg_pat = 7'h00;
    endcase
  end

`ifdef SSEG_DIM_EN
  logic [3:0] phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase <= 4'd0;
    else       phase <= phase + 4'd1;
  end

  assign lit = (cnt >= CNT_BLANK) && !snap[4] && (phase <= dim);
`else
  assign lit = (cnt >= CNT_BLANK) && !snap[4];
`endif

  assign an_int   = lit ? (4'b0001 << digit_idx) : 4'b0000;
  assign sseg_int = lit ? {snap[5], seg_pat} : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      digit_idx <= 2'd0;
      scan_tick <= 1'b0;
      snap      <= 6'b01_0000;
      an        <= AN_OFF;
      sseg      <= SSEG_OFF;
    end else begin
      scan_tick <= slot_end;
      if (slot_end) begin
        cnt       <= '0;
        digit_idx <= idx_nxt;
        snap      <= snap_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // XOR with the off pattern applies the pin polarity
      an   <= an_int ^ AN_OFF;
      sseg <= sseg_int ^ SSEG_OFF;
    end
  end

endmodule

// File: tb/tb_sseg_mux4.sv
// Scoreboard bench for sseg_mux4: slot-level reference model pushes expectations, a monitor pops and compares.
module tb_sseg_mux4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] in_0 = 5'h0, in_1 = 5'h0, in_2 = 5'h0, in_3 = 5'h0;
  logic [3:0] dp_in = 4'h0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [1:0] digit_idx;
  logic       scan_tick;
`ifdef SSEG_DIM_EN
  logic [3:0] dim = 4'hF;
`endif

  sseg_mux4 #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3), .dp_in(dp_in),
`ifdef SSEG_DIM_EN
    .dim(dim),
`endif
    .an(an), .sseg(sseg), .digit_idx(digit_idx), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [5:0] snap_of [256];   // {dp, blank, hex} latched for each slot number
  logic [4:0] w [4];
  logic [3:0] dp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("an", 32'(an), 32'(e.an));
        check("sseg", 32'(sseg), 32'(e.sseg));
        check("digit_idx", 32'(digit_idx), 32'(e.idx));
        check("scan_tick", 32'(scan_tick), 32'(e.tick));
      end
    end
  end

  task automatic push_reset_exp();
    exp_t e;
    e.an = 4'hF; e.sseg = 8'hFF; e.idx = 2'd0; e.tick = 1'b0;
    q.push_back(e);
  endtask

  task automatic pick_inputs(input int k, input bit rnd);
    if (rnd || k >= 144) begin
      if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 3)] = 5'($urandom);
      if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
    end else begin
      case (k)
        1:   begin w[0] = 5'h00; w[1] = 5'h01; w[2] = 5'h02; w[3] = 5'h03; dp = 4'h0; end
        41:  w[2] = 5'h15;
        76:  w[1] = 5'h0A;
        80:  begin w[2] = 5'h08; dp = 4'b0100; end
        112: w[2] = 5'h0E;
        default: ;
      endcase
    end
    in_0 = w[0]; in_1 = w[1]; in_2 = w[2]; in_3 = w[3]; dp_in = dp;
  endtask

  // k counts clock edges since reset release; expectation is for the sample after edge k
  task automatic run(input int n, input bit rnd);
    for (int s = 0; s < 256; s++) snap_of[s] = 6'b01_0000;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= n; k++) begin
      exp_t e;
      int   d, s, p;
      logic [5:0] sn;
      bit   lit;
      pick_inputs(k, rnd);
      if (k % RD == 0) begin
        d = (k / RD) % 4;
        snap_of[k / RD] = {dp[d], w[d]};
      end
      s   = (k - 1) / RD;
      p   = (k - 1) % RD;
      sn  = snap_of[s];
      lit = (p >= BC) && !sn[4];
      e.an   = lit ? ~(4'b0001 << (s % 4)) : 4'hF;
      e.sseg = lit ? ~{sn[5], pat[sn[3:0]]} : 8'hFF;
      e.idx  = 2'((k / RD) % 4);
      e.tick = (k % RD == 0) && (k >= RD);
      q.push_back(e);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) w[i] = 5'h00;
    dp = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      push_reset_exp();
    end
    run(301, 1'b0);
    // asynchronous reset in the middle of a lit slot
    reset = 1'b1;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_sseg", 32'(sseg), 32'hFF);
    check("async_idx", 32'(digit_idx), 32'h0);
    check("async_tick", 32'(scan_tick), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push_reset_exp();
    end
    run(150, 1'b1);
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
